// File: rtl/mem_responder.sv
// Word-array memory responder for the rv32i memory port with programmable wait states.
// One request at a time; mem_resp pulses WAIT_CYCLES+1 cycles after the request appears.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  write_q;
    logic                  err_q;
    logic                  resp_q;
    logic                  error_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  req_err_d;
    logic [ADDR_WIDTH-1:0] req_idx_d;
    logic                  sel_err_d;
    logic                  sel_write_d;
    logic [ADDR_WIDTH-1:0] sel_idx_d;
    logic [31:0]           rdata_d;

    assign req_idx_d = mem_address[ADDR_WIDTH+1:2];
    assign req_err_d = (mem_read & mem_write) | ((mem_address >> (ADDR_WIDTH + 2)) != 32'd0);

    // RESP is entered from IDLE (zero wait) using live inputs, otherwise from the latched copy.
    always_comb begin
        sel_err_d   = err_q;
        sel_write_d = write_q;
        sel_idx_d   = idx_q;
        if (state_q == IDLE) begin
            sel_err_d   = req_err_d;
            sel_write_d = mem_write;
            sel_idx_d   = req_idx_d;
        end
        rdata_d = rdata_q;
        if (sel_err_d) begin
            rdata_d = 32'd0;
        end else if (!sel_write_d) begin
            rdata_d = mem_q[sel_idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        idx_q   <= req_idx_d;
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        write_q <= mem_write;
                        err_q   <= req_err_d;
                        cnt_q   <= CW'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            error_q <= sel_err_d;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        error_q <= sel_err_d;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; a reset during RESP leaves state_q in IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (state_q == RESP && write_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_resp  = resp_q;
    assign mem_error = error_q;
    assign mem_rdata = rdata_q;

endmodule
